// File: rtl/mem_bus_ctrl_if.sv
// Signal bundle between the CPU memory port, mem_bus_ctrl and the 64 kB memory model.
// Handshake: a request transfers at a rising edge where cpu_req && cpu_ready; results return as
// one-cycle cpu_rvalid / cpu_wdone pulses that the requester must take (no back-pressure).
interface mem_bus_ctrl_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
);
  logic                    cpu_req;
  logic                    cpu_we;
  logic                    cpu_word;
  logic [ADDR_WIDTH-1:0]   cpu_addr;
  logic [DATA_WIDTH-1:0]   cpu_wdata;
  logic                    cpu_ready;
  logic                    cpu_rvalid;
  logic [2*DATA_WIDTH-1:0] cpu_rdata;
  logic                    cpu_wdone;
  logic                    mem_enable;
  logic                    mem_wr_enable;
  logic [ADDR_WIDTH-1:0]   mem_address;
  logic [DATA_WIDTH-1:0]   mem_wr_data;
  logic [DATA_WIDTH-1:0]   mem_rd_data;

  // Environment side: CPU request source plus memory read data.
  modport master (
    output cpu_req, cpu_we, cpu_word, cpu_addr, cpu_wdata, mem_rd_data,
    input  cpu_ready, cpu_rvalid, cpu_rdata, cpu_wdone,
    input  mem_enable, mem_wr_enable, mem_address, mem_wr_data
  );

  // Controller side.
  modport slave (
    input  cpu_req, cpu_we, cpu_word, cpu_addr, cpu_wdata, mem_rd_data,
    output cpu_ready, cpu_rvalid, cpu_rdata, cpu_wdone,
    output mem_enable, mem_wr_enable, mem_address, mem_wr_data
  );
endinterface

// File: rtl/mem_bus_ctrl.sv
// Bus sequencer between the 6502 memory port and a registered-read memory: byte read/write, 16-bit LE word read.
// Define PAGE_WRAP_EN to keep the word-read hi address inside the lo byte's page (NMOS indirect quirk).
module mem_bus_ctrl #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int RD_LATENCY = 1
) (
  input  logic         clk,
  input  logic         reset,
  mem_bus_ctrl_if.slave bus,
  output logic [2:0]   dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WRITE   = 3'd1,
    S_RD_LO   = 3'd2,
    S_WAIT_LO = 3'd3,
    S_RD_HI   = 3'd4,
    S_WAIT_HI = 3'd5
  } state_e;

  localparam logic [2:0] LAT_M1 = 3'(RD_LATENCY - 1);

  state_e                  state_q;
  logic [2:0]              cnt_q;
  logic                    word_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   lo_q;
  logic [2*DATA_WIDTH-1:0] rdata_q;
  logic                    rvalid_q;
  logic                    wdone_q;
  logic                    mem_en_q;
  logic                    mem_we_q;
  logic [ADDR_WIDTH-1:0]   mem_addr_q;
  logic [DATA_WIDTH-1:0]   mem_wdata_q;
  logic [ADDR_WIDTH-1:0]   hi_addr;

`ifdef PAGE_WRAP_EN
  // Carry out of the low address byte is dropped, so $xxFF wraps to $xx00.
  assign hi_addr = {addr_q[ADDR_WIDTH-1:8], addr_q[7:0] + 8'd1};
`else
  assign hi_addr = addr_q + ADDR_WIDTH'(1);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 3'd0;
      word_q      <= 1'b0;
      addr_q      <= '0;
      lo_q        <= '0;
      rdata_q     <= '0;
      rvalid_q    <= 1'b0;
      wdone_q     <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      rvalid_q <= 1'b0;
      wdone_q  <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (bus.cpu_req) begin
            addr_q     <= bus.cpu_addr;
            word_q     <= bus.cpu_word && !bus.cpu_we;
            mem_en_q   <= 1'b1;
            mem_addr_q <= bus.cpu_addr;
            if (bus.cpu_we) begin
              mem_we_q    <= 1'b1;
              mem_wdata_q <= bus.cpu_wdata;
              state_q     <= S_WRITE;
            end else begin
              mem_we_q <= 1'b0;
              state_q  <= S_RD_LO;
            end
          end
        end
        S_WRITE: begin
          mem_en_q <= 1'b0;
          mem_we_q <= 1'b0;
          wdone_q  <= 1'b1;
          state_q  <= S_IDLE;
        end
        S_RD_LO: begin
          mem_en_q <= 1'b0;
          cnt_q    <= LAT_M1;
          state_q  <= S_WAIT_LO;
        end
        S_WAIT_LO: begin
          if (cnt_q == 3'd0) begin
            lo_q <= bus.mem_rd_data;
            if (word_q) begin
              mem_en_q   <= 1'b1;
              mem_addr_q <= hi_addr;
              state_q    <= S_RD_HI;
            end else begin
              rvalid_q <= 1'b1;
              rdata_q  <= {{DATA_WIDTH{1'b0}}, bus.mem_rd_data};
              state_q  <= S_IDLE;
            end
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        S_RD_HI: begin
          mem_en_q <= 1'b0;
          cnt_q    <= LAT_M1;
          state_q  <= S_WAIT_HI;
        end
        S_WAIT_HI: begin
          if (cnt_q == 3'd0) begin
            rvalid_q <= 1'b1;
            rdata_q  <= {bus.mem_rd_data, lo_q};
            state_q  <= S_IDLE;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Ready is combinational so the result cycle can also accept the next request.
  assign bus.cpu_ready     = (state_q == S_IDLE) && !reset;
  assign bus.cpu_rvalid    = rvalid_q;
  assign bus.cpu_rdata     = rdata_q;
  assign bus.cpu_wdone     = wdone_q;
  assign bus.mem_enable    = mem_en_q;
  assign bus.mem_wr_enable = mem_we_q;
  assign bus.mem_address   = mem_addr_q;
  assign bus.mem_wr_data   = mem_wdata_q;
  assign dbg_state_o       = state_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl: one instance at RD_LATENCY=1 and one at RD_LATENCY=3 sharing a memory model.
module tb_mem_bus_ctrl;
  localparam int AW = 16;
  localparam int DW = 8;
  localparam int W  = 49;  // {is_write, rdata[15:0], due_cycle[31:0]}

`ifdef PAGE_WRAP_EN
  localparam logic [15:0] EXP_FFFF = 16'h5634;
  localparam logic [15:0] EXP_10FF = 16'hBC78;
`else
  localparam logic [15:0] EXP_FFFF = 16'h1234;
  localparam logic [15:0] EXP_10FF = 16'h9A78;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  mem_bus_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus1 ();
  mem_bus_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus3 ();
  logic [2:0] dbg1, dbg3;

  mem_bus_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1), .dbg_state_o(dbg1)
  );
  mem_bus_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset), .bus(bus3), .dbg_state_o(dbg3)
  );

  // ---------------- memory model ----------------
  logic [7:0]  mem [0:65535];
  logic [7:0]  rd1 = 8'h00;
  logic [7:0]  rd3 = 8'h00;
  logic        pre_we = 1'b0;
  logic [15:0] pre_addr = 16'h0000;
  logic [7:0]  pre_data = 8'h00;

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (bus1.mem_enable && bus1.mem_wr_enable) mem[bus1.mem_address] <= bus1.mem_wr_data;
    if (bus1.mem_enable && !bus1.mem_wr_enable) rd1 <= mem[bus1.mem_address];
    if (bus3.mem_enable && !bus3.mem_wr_enable) rd3 <= mem[bus3.mem_address];
  end
  assign bus1.mem_rd_data = rd1;
  assign bus3.mem_rd_data = rd3;

  // ---------------- checking ----------------
  int n_pass = 0;
  int n_total = 0;
  logic [W-1:0] exp_q1[$];
  logic [W-1:0] exp_q3[$];
  logic [W-1:0] e1, e3;
  int en3_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic fail(input string name);
    n_total++;
    $display("FAIL %s: got event expected none/other (cycle %0d)", name, cyc);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (bus3.mem_enable) en3_cnt++;
      if (bus1.cpu_rvalid || bus1.cpu_wdone) begin
        if (exp_q1.size() == 0) fail("unexpected_resp1");
        else begin
          e1 = exp_q1.pop_front();
          chk("pulse1", {30'd0, bus1.cpu_rvalid, bus1.cpu_wdone}, e1[48] ? 32'd1 : 32'd2);
          chk("ready_at_resp1", {31'd0, bus1.cpu_ready}, 32'd1);
          chk("due_cycle1", cyc, e1[31:0]);
          if (!e1[48]) chk("rdata1", {16'd0, bus1.cpu_rdata}, {16'd0, e1[47:32]});
        end
      end
      if (bus3.cpu_rvalid || bus3.cpu_wdone) begin
        if (exp_q3.size() == 0) fail("unexpected_resp3");
        else begin
          e3 = exp_q3.pop_front();
          chk("pulse3", {30'd0, bus3.cpu_rvalid, bus3.cpu_wdone}, 32'd2);
          chk("ready_at_resp3", {31'd0, bus3.cpu_ready}, 32'd1);
          chk("due_cycle3", cyc, e3[31:0]);
          chk("rdata3", {16'd0, bus3.cpu_rdata}, {16'd0, e3[47:32]});
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic preload(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(posedge clk);
    #1 pre_we = 1'b0;
  endtask

  task automatic issue1(input logic we, input logic word, input logic [15:0] a,
                        input logic [7:0] wd, input logic [15:0] exp, input bit expect_resp);
    int n;
    int lat;
    n = 0;
    @(negedge clk);
    while (!bus1.cpu_ready && n < 100) begin @(negedge clk); n++; end
    if (!bus1.cpu_ready) begin fail("ready_timeout1"); return; end
    bus1.cpu_req = 1'b1; bus1.cpu_we = we; bus1.cpu_word = word;
    bus1.cpu_addr = a; bus1.cpu_wdata = wd;
    lat = we ? 1 : (word ? 4 : 2);
    if (expect_resp) exp_q1.push_back({we, exp, 32'(cyc + 1 + lat)});
    @(posedge clk);
    #1 bus1.cpu_req = 1'b0;
  endtask

  // Holds cpu_req high and moves cpu_addr after acceptance; drops req in the result cycle.
  task automatic issue3_hold(input logic word, input logic [15:0] a, input logic [15:0] a_new,
                             input logic [15:0] exp);
    int n;
    int due;
    n = 0;
    @(negedge clk);
    while (!bus3.cpu_ready && n < 100) begin @(negedge clk); n++; end
    if (!bus3.cpu_ready) begin fail("ready_timeout3"); return; end
    en3_cnt = 0;
    bus3.cpu_req = 1'b1; bus3.cpu_we = 1'b0; bus3.cpu_word = word; bus3.cpu_addr = a;
    due = cyc + 1 + (word ? 8 : 4);
    exp_q3.push_back({1'b0, exp, 32'(due)});
    @(posedge clk);
    #1 bus3.cpu_addr = a_new;
    n = 0;
    while (cyc != due && n < 50) begin @(negedge clk); n++; end
    bus3.cpu_req = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q1.size() != 0 || exp_q3.size() != 0) && n < 100) begin @(negedge clk); n++; end
    if (exp_q1.size() != 0 || exp_q3.size() != 0) begin
      fail("drain_timeout");
      exp_q1.delete();
      exp_q3.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    bus1.cpu_req = 1'b0; bus1.cpu_we = 1'b0; bus1.cpu_word = 1'b0;
    bus1.cpu_addr = '0; bus1.cpu_wdata = '0;
    bus3.cpu_req = 1'b0; bus3.cpu_we = 1'b0; bus3.cpu_word = 1'b0;
    bus3.cpu_addr = '0; bus3.cpu_wdata = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready1", {31'd0, bus1.cpu_ready}, 32'd0);
    chk("rst_ready3", {31'd0, bus3.cpu_ready}, 32'd0);
    chk("rst_rvalid1", {31'd0, bus1.cpu_rvalid}, 32'd0);
    chk("rst_wdone1", {31'd0, bus1.cpu_wdone}, 32'd0);
    chk("rst_rdata1", {16'd0, bus1.cpu_rdata}, 32'd0);
    chk("rst_mem_en1", {31'd0, bus1.mem_enable}, 32'd0);
    chk("rst_mem_we1", {31'd0, bus1.mem_wr_enable}, 32'd0);
    chk("rst_mem_addr1", {16'd0, bus1.mem_address}, 32'd0);
    chk("rst_mem_wdata1", {24'd0, bus1.mem_wr_data}, 32'd0);
    chk("rst_state1", {29'd0, dbg1}, 32'd0);
    chk("rst_state3", {29'd0, dbg3}, 32'd0);

    preload(16'h0200, 8'hA9);
    preload(16'hFFFC, 8'h00);
    preload(16'hFFFD, 8'h80);
    preload(16'hFFFF, 8'h34);
    preload(16'h0000, 8'h12);
    preload(16'hFF00, 8'h56);
    preload(16'h10FF, 8'h78);
    preload(16'h1100, 8'h9A);
    preload(16'h1000, 8'hBC);

    @(negedge clk);
    reset = 1'b0;
    #1 chk("ready_after_rst1", {31'd0, bus1.cpu_ready}, 32'd1);

    // Byte read $0200, strobe exactly one cycle
    issue1(1'b0, 1'b0, 16'h0200, 8'h00, 16'h00A9, 1'b1);
    @(negedge clk);
    chk("br_en_issue", {31'd0, bus1.mem_enable}, 32'd1);
    chk("br_we_issue", {31'd0, bus1.mem_wr_enable}, 32'd0);
    chk("br_addr_issue", {16'd0, bus1.mem_address}, 32'h0200);
    @(negedge clk);
    chk("br_en_wait", {31'd0, bus1.mem_enable}, 32'd0);
    drain();

    // Word read reset vector $FFFC
    issue1(1'b0, 1'b1, 16'hFFFC, 8'h00, 16'h8000, 1'b1);
    @(negedge clk);
    chk("wr_addr_lo", {15'd0, bus1.mem_enable, bus1.mem_address}, 32'h1FFFC);
    @(negedge clk);
    chk("wr_en_wait_lo", {31'd0, bus1.mem_enable}, 32'd0);
    @(negedge clk);
    chk("wr_addr_hi", {15'd0, bus1.mem_enable, bus1.mem_address}, 32'h1FFFD);
    @(negedge clk);
    chk("wr_hold_addr", {15'd0, bus1.mem_enable, bus1.mem_address}, 32'h0FFFD);
    drain();

    // Address wrap on the hi byte
    issue1(1'b0, 1'b1, 16'hFFFF, 8'h00, EXP_FFFF, 1'b1);
    drain();
    issue1(1'b0, 1'b1, 16'h10FF, 8'h00, EXP_10FF, 1'b1);
    drain();

    // Write then back-to-back byte read of the same location
    issue1(1'b1, 1'b0, 16'h0300, 8'h5A, 16'h0000, 1'b1);
    @(negedge clk);
    chk("wr_strobes", {30'd0, bus1.mem_enable, bus1.mem_wr_enable}, 32'd3);
    chk("wr_addr_data", {8'd0, bus1.mem_address, bus1.mem_wr_data}, 32'h03005A);
    issue1(1'b0, 1'b0, 16'h0300, 8'h00, 16'h005A, 1'b1);
    drain();
    repeat (2) @(negedge clk);
    chk("rdata_hold", {16'd0, bus1.cpu_rdata}, 32'h005A);
    chk("wdata_hold", {24'd0, bus1.mem_wr_data}, 32'h5A);

    // Reset during WAIT_HI drops the read
    issue1(1'b0, 1'b1, 16'hFFFC, 8'h00, 16'h0000, 1'b0);
    repeat (4) @(negedge clk);
    chk("state_wait_hi", {29'd0, dbg1}, 32'd5);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_outs", {29'd0, bus1.cpu_rvalid, bus1.cpu_wdone, bus1.cpu_ready}, 32'd0);
    chk("mid_rst_rdata", {16'd0, bus1.cpu_rdata}, 32'd0);
    chk("mid_rst_mem", {14'd0, bus1.mem_enable, bus1.mem_wr_enable, bus1.mem_address}, 32'd0);
    chk("mid_rst_wdata", {24'd0, bus1.mem_wr_data}, 32'd0);
    reset = 1'b0;
    #1 chk("ready_post_rst", {31'd0, bus1.cpu_ready}, 32'd1);
    @(negedge clk);
    chk("idle_post_rst", {30'd0, bus1.cpu_ready, bus1.cpu_rvalid}, 32'd2);
    issue1(1'b0, 1'b0, 16'h0200, 8'h00, 16'h00A9, 1'b1);
    drain();

    // RD_LATENCY=3 with req held and address moved after acceptance
    issue3_hold(1'b0, 16'h0200, 16'h0300, 16'h00A9);
    drain();
    repeat (12) @(negedge clk);
    chk("hold_byte_issues", en3_cnt, 32'd1);
    issue3_hold(1'b1, 16'hFFFC, 16'h0200, 16'h8000);
    drain();
    repeat (12) @(negedge clk);
    chk("hold_word_issues", en3_cnt, 32'd2);

    chk("q1_empty", exp_q1.size(), 32'd0);
    chk("q3_empty", exp_q3.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
